uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 2-of-3 mid-bit voting and a frame FIFO
module uart_rx_cfg #(
  parameter int DWIDTH     = 8,
  parameter int PWIDTH     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_data,
  input  logic [PWIDTH-1:0]         prescale,
  input  logic [$clog2(DWIDTH)-1:0] data_len,
  input  logic                      parity_en,
  input  logic                      parity_type,
  input  logic                      stop_bits,
  output logic [DWIDTH-1:0]         p_data,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int LW = $clog2(DWIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PWIDTH-1:0] P_ONE  = PWIDTH'(1);
  localparam logic [PWIDTH-1:0] P_TWO  = PWIDTH'(2);
  localparam logic [LW-1:0]     B_ONE  = LW'(1);
  localparam logic [LW-1:0]     L_MAX  = LW'(DWIDTH - 1);
  localparam logic [AW-1:0]     A_ONE  = AW'(1);
  localparam logic [AW:0]       C_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]       C_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t              state_q, state_d;
  logic                s_meta_q, s_sync_q, s_prev_q;
  logic [PWIDTH-1:0]   cnt_q, cnt_d, presc_q, presc_d;
  logic [LW-1:0]       bit_q, bit_d, len_q, len_d;
  logic [DWIDTH-1:0]   shreg_q, shreg_d;
  logic [1:0]          samp_q, samp_d;
  logic                pbit_q, pbit_d, ferr_q, ferr_d;
  logic                pen_q, pen_d, ptype_q, ptype_d, stop2_q, stop2_d;
  logic                perr_q, ferr_out_q, ovr_q;
  logic [DWIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         fcnt_q;

  logic [PWIDTH-1:0]   half;
  logic                at_s0, at_s1, at_vote, at_wrap, vote, fall;
  logic                done, frame_ferr, par_bad, good, push, pop, full, ovr;
  logic [DWIDTH-1:0]   data_word;

  assign half    = presc_q >> 1;
  assign at_s0   = (cnt_q == half - P_TWO);
  assign at_s1   = (cnt_q == half - P_ONE);
  assign at_vote = (cnt_q == half);
  assign at_wrap = (cnt_q == presc_q - P_ONE);
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_sync_q) | (samp_q[1] & s_sync_q);
  assign fall    = s_prev_q & ~s_sync_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = at_wrap ? '0 : cnt_q + P_ONE;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    samp_d     = samp_q;
    pbit_d     = pbit_q;
    ferr_d     = ferr_q;
    presc_d    = presc_q;
    len_d      = len_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    stop2_d    = stop2_q;
    done       = 1'b0;
    frame_ferr = 1'b0;
    if (at_s0) samp_d[0] = s_sync_q;
    if (at_s1) samp_d[1] = s_sync_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) begin
          state_d = START;
          presc_d = prescale;
          len_d   = data_len;
          pen_d   = parity_en;
          ptype_d = parity_type;
          stop2_d = stop_bits;
          shreg_d = '0;
          pbit_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[DWIDTH-1:1]};
        if (at_wrap) begin
          if (bit_q == len_q) begin
            state_d = pen_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + B_ONE;
          end
        end
      end
      PARITY: begin
        if (at_vote) pbit_d = vote;
        if (at_wrap) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        // The frame finishes mid-bit so the next start edge can be caught early.
        if (at_vote) begin
          if (stop2_q && bit_q == '0) begin
            ferr_d = ~vote;
          end else begin
            done       = 1'b1;
            frame_ferr = ferr_q | ~vote;
            state_d    = frame_ferr ? WAIT_HIGH : IDLE;
            cnt_d      = '0;
          end
        end
        if (at_wrap) bit_d = bit_q + B_ONE;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (s_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_word = shreg_q >> (L_MAX - len_q);
  assign par_bad   = pen_q & ((^{shreg_q, pbit_q}) != ptype_q);
  assign good      = done & ~frame_ferr & ~par_bad;
  assign data_valid = (fcnt_q != '0);
  assign pop       = data_valid & data_ready;
  assign full      = (fcnt_q == C_FULL);
  assign push      = good & (~full | pop);
  assign ovr       = good & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta_q   <= 1'b1;
      s_sync_q   <= 1'b1;
      s_prev_q   <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      samp_q     <= '0;
      pbit_q     <= 1'b0;
      ferr_q     <= 1'b0;
      presc_q    <= '0;
      len_q      <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      s_meta_q   <= s_data;
      s_sync_q   <= s_meta_q;
      s_prev_q   <= s_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      samp_q     <= samp_d;
      pbit_q     <= pbit_d;
      ferr_q     <= ferr_d;
      presc_q    <= presc_d;
      len_q      <= len_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
      stop2_q    <= stop2_d;
      perr_q     <= done & ~frame_ferr & par_bad;
      ferr_out_q <= done & frame_ferr;
      ovr_q      <= ovr;
      if (push) wr_ptr_q <= wr_ptr_q + A_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + A_ONE;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + C_ONE;
        2'b01:   fcnt_q <= fcnt_q - C_ONE;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_word;
  end

  assign p_data        = data_valid ? mem_q[rd_ptr_q] : '0;
  assign parity_error  = perr_q;
  assign framing_error = ferr_out_q;
  assign overrun       = ovr_q;

endmodule
